// File: rtl/risc_pkg.sv
// Shared fetch-path types: address/instruction widths, fetch FSM states,
// the prefetch entry layout and small arithmetic helpers.
package risc_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;
    localparam int CNT_W   = 32;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Instructions are halfword aligned; the low address bit is never meaningful.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:1], 1'b0};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous prefetch FIFO with flush; head entry is presented
// straight from storage and reads as zero while the FIFO is empty.
module fetch_fifo
    import risc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    // NOTE: storage carries no reset; validity lives entirely in count, so
    // stale slots are never observable and the array can map onto plain flops/RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: sequential prefetch into a small buffer,
// redirect flush, halt. Optional perf counters under `FETCH_PERF_CNT_EN.
module instr_fetch_ctrl
    import risc_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    imem_pc,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [PC_W-1:0]    dec_pc,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic               fetch_idle
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   perf_fetch_cnt,
    output logic [CNT_W-1:0]   perf_stall_cnt
`endif
);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [PC_W-1:0] fetch_pc_q;
    logic [PC_W-1:0] fetch_pc_d;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_flush;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    assign imem_pc    = fetch_pc_q;
    assign push_entry = '{pc: fetch_pc_q, instr: imem_instr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH_RUN;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the branches can leave a latch behind.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        // The mode follows halt one edge later, independent of redirects.
        case (state_q)
            FETCH_RUN:  if (halt)  state_d = FETCH_HALT;
            FETCH_HALT: if (!halt) state_d = FETCH_RUN;
            default:    state_d = FETCH_RUN;
        endcase

        if (redirect_valid) begin
            fifo_flush = 1'b1;
            fetch_pc_d = align_pc(redirect_pc);
        end else begin
            fifo_pop = !fifo_empty && dec_ready;
            if (state_q == FETCH_RUN && (!fifo_full || fifo_pop)) begin
                fifo_push  = 1'b1;
                fetch_pc_d = fetch_pc_q + PC_W'(2);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (fifo_flush),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (head_entry),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign dec_valid  = !fifo_empty;
    assign dec_pc     = head_entry.pc;
    assign dec_instr  = head_entry.instr;
    assign fetch_idle = (state_q == FETCH_HALT) && fifo_empty;

`ifdef FETCH_PERF_CNT_EN
    // Counters survive redirects; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fifo_push) begin
                perf_fetch_cnt <= sat_inc(perf_fetch_cnt);
            end
            if (dec_valid && !dec_ready) begin
                perf_stall_cnt <= sat_inc(perf_stall_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared against a queue-based model.
module tb_instr_fetch_ctrl;

    localparam int          DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_pc;
    logic [15:0] imem_instr;
    logic        dec_valid;
    logic        dec_ready;
    logic [15:0] dec_instr;
    logic [15:0] dec_pc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        fetch_idle;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    logic [15:0] mem [16];
    assign imem_instr = mem[imem_pc[4:1]];

    instr_fetch_ctrl #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .fetch_idle     (fetch_idle)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is a plain queue of {pc, instr} records.
    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_pc;
    bit          m_halted;
    longint      m_fetches;
    longint      m_stalls;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pc      = RESET_PC;
            m_halted  = 0;
            m_fetches = 0;
            m_stalls  = 0;
        end else begin
            bit take;
            bit give;
            take = (mq.size() > 0) && dec_ready;
            give = !m_halted && ((mq.size() < DEPTH) || take);
            if ((mq.size() > 0) && !dec_ready) m_stalls++;
            if (redirect_valid) begin
                mq.delete();
                m_pc = redirect_pc & 16'hFFFE;
            end else begin
                if (take) void'(mq.pop_front());
                if (give) begin
                    ent_t e;
                    e.pc    = m_pc;
                    e.instr = mem[m_pc[4:1]];
                    mq.push_back(e);
                    m_pc = m_pc + 16'd2;
                    m_fetches++;
                end
            end
            m_halted = halt;
        end
    end

    always @(negedge clk) begin
        check("dec_valid", 32'(dec_valid), 32'(mq.size() > 0));
        check("dec_pc", 32'(dec_pc), 32'((mq.size() > 0) ? mq[0].pc : 16'h0));
        check("dec_instr", 32'(dec_instr), 32'((mq.size() > 0) ? mq[0].instr : 16'h0));
        check("imem_pc", 32'(imem_pc), 32'(m_pc));
        check("fetch_idle", 32'(fetch_idle), 32'(m_halted && (mq.size() == 0)));
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetch_cnt", perf_fetch_cnt, 32'(m_fetches));
        check("perf_stall_cnt", perf_stall_cnt, 32'(m_stalls));
`endif
    end

    // Inputs change 2 time units after the active edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_seq();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        dec_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        halt           = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) mem[i] = 16'h1001 + 16'(i);

        // Straight-line fetch right after reset.
        dec_ready = 1'b1;
        reset_seq();
        for (int i = 0; i < 4; i++) begin
            step();
            check("seq_valid", 32'(dec_valid), 32'd1);
            check("seq_pc", 32'(dec_pc), 32'(2 * i));
            check("seq_instr", 32'(dec_instr), 32'(16'h1001 + 16'(i)));
        end

        // Decoder stall fills the buffer, then drains without loss.
        dec_ready = 1'b0;
        reset_seq();
        repeat (5) step();
        check("stall_head_pc", 32'(dec_pc), 32'h0);
        check("stall_imem_pc", 32'(imem_pc), 32'h4);
        dec_ready = 1'b1;
        step();
        check("drain_pc1", 32'(dec_pc), 32'h2);
        step();
        check("drain_pc2", 32'(dec_pc), 32'h4);

        // Redirect onto an odd address while full.
        dec_ready = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0013;
        step();
        redirect_valid = 1'b0;
        check("redir_flush_valid", 32'(dec_valid), 32'd0);
        check("redir_imem_pc", 32'(imem_pc), 32'h12);
        step();
        check("redir_valid", 32'(dec_valid), 32'd1);
        check("redir_pc", 32'(dec_pc), 32'h12);

        // Halt with two entries buffered.
        dec_ready = 1'b0;
        reset_seq();
        step();
        step();
        halt      = 1'b1;
        dec_ready = 1'b1;
        repeat (3) step();
        check("halt_idle", 32'(fetch_idle), 32'd1);
        check("halt_valid", 32'(dec_valid), 32'd0);
        check("halt_imem_pc", 32'(imem_pc), 32'h6);
        step();
        check("halt_imem_hold", 32'(imem_pc), 32'h6);
        halt = 1'b0;
        step();
        check("resume_idle", 32'(fetch_idle), 32'd0);
        step();
        check("resume_pc", 32'(dec_pc), 32'h6);

        // Address wrap at the top of the space.
        dec_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFC;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] exp_pc;
            exp_pc = 16'hFFFC + 16'(2 * i);
            step();
            check("wrap_pc", 32'(dec_pc), 32'(exp_pc));
        end

        // Asynchronous reset in mid-stream.
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(dec_valid), 32'd0);
        check("async_rst_pc", 32'(dec_pc), 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("async_rst_fetch_cnt", perf_fetch_cnt, 32'd0);
        check("async_rst_stall_cnt", perf_stall_cnt, 32'd0);
`endif
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_pc", 32'(dec_pc), 32'(RESET_PC));
        check("post_rst_valid", 32'(dec_valid), 32'd1);

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            dec_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 16'($urandom);
            if ($urandom_range(0, 24) == 0) halt = ~halt;
            rst_n = ($urandom_range(0, 399) != 0);
            step();
        end
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter: DEPTH, 2, prefetch buffer entries (power of two, 2..8).
REQ-002 Parameter: RESET_PC, 16'h0000, fetch address after reset (bit 0 = 0).
REQ-003 Port: clk  in  1  single clock; all state on rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 Port: imem_pc  out  16  byte address to instruction memory; memory indexes word pc[4:1], read is combinational.
REQ-006 Port: imem_instr  in  16  instruction word for imem_pc, valid same cycle.
REQ-007 Port: dec_valid  out  1  head-of-buffer entry valid toward decoder.
REQ-008 Port: dec_ready  in  1  decoder accepts; transfer when dec_valid && dec_ready.
REQ-009 Port: dec_instr  out  16  head-entry instruction.
REQ-010 Port: dec_pc  out  16  head-entry address.
REQ-011 Port: redirect_valid  in  1  branch/jump taken, one-cycle pulse.
REQ-012 Port: redirect_pc  in  16  new fetch address; bit 0 ignored (treated as 0).
REQ-013 Port: halt  in  1  level; stop issuing fetches while high.
REQ-014 Port: fetch_idle  out  1  high when state HALT and buffer empty.

Function
REQ-015 FSM states RUN, HALT; RUN -> HALT when halt=1; HALT -> RUN when halt=0; transition takes effect next edge.
REQ-016 imem_pc shall equal the fetch_pc register at all times.
REQ-017 In RUN, push {fetch_pc, imem_instr} and fetch_pc += 2 each edge the buffer is not full or a pop occurs that edge.
REQ-018 Pop on dec_valid && dec_ready; push and pop on the same edge when full shall both succeed, count unchanged.
REQ-019 dec_valid = buffer non-empty; dec_instr/dec_pc from head entry, registered, no combinational path from dec_ready.
REQ-020 Latency: first push one edge after rst_n deassert; dec_valid high from the following cycle with dec_pc = RESET_PC.
REQ-021 Addresses leave the buffer in strictly increasing order (+2) between redirects; no entry dropped or duplicated.
REQ-022 fetch_pc wraps 16'hFFFE -> 16'h0000 without error; word aliasing by pc[4:1] is the memory's concern.
REQ-023 redirect_valid: on that edge flush buffer, cancel push and pop, fetch_pc <= {redirect_pc[15:1],1'b0}; dec_valid low next cycle.
REQ-024 Redirect takes priority over halt, push and pop; redirect while HALT loads fetch_pc, flushes, stays HALT.
REQ-025 HALT: no push, fetch_pc holds; buffered entries still drain to decoder.
REQ-026 Full buffer in RUN: fetch_pc holds, imem_pc stable.

Reset
REQ-027 rst_n low: fetch_pc = RESET_PC, buffer empty, state RUN, dec_valid 0, dec_instr 0, dec_pc 0, fetch_idle 0, counters 0.
REQ-028 Reset mid-operation discards all buffered entries immediately (asynchronous).

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN defined: add outputs perf_fetch_cnt (out 32, pushes) and perf_stall_cnt (out 32, cycles with dec_valid && !dec_ready); both saturate at all-ones and are not cleared by redirect.
REQ-030 Macro undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-031 Shared package risc_pkg: PC_W=16, INSTR_W=16, fetch-state enum, fetch-entry struct {pc, instr}.
REQ-032 Sub-module fetch_fifo (DEPTH-entry sync FIFO, flush input, full/empty) instantiated once.

Verification
REQ-033 Reset release, dec_ready=1, memory words 0..3 = 16'h1001..16'h1004 -> dec_pc 0,2,4,6 with those instructions on consecutive cycles.
REQ-034 dec_ready=0 for 5 cycles, DEPTH=2 -> buffer holds pc 0,2; imem_pc stays 16'h0004; release -> 0,2,4 delivered in order, no loss.
REQ-035 redirect_valid with redirect_pc=16'h0013 while buffer full -> next cycle dec_valid=0, then dec_pc=16'h0012, old entries never delivered.
REQ-036 halt=1 with 2 entries buffered, dec_ready=1 -> both drain, fetch_idle=1, imem_pc constant; halt=0 -> fetching resumes at held pc.
REQ-037 redirect_pc=16'hFFFC, dec_ready=1 -> dec_pc sequence FFFC, FFFE, 0000, 0002.
REQ-038 rst_n low mid-stream with dec_valid=1 -> dec_valid 0 immediately; after release dec_pc=RESET_PC first (with FETCH_PERF_CNT_EN: counters 0).
